// File: rtl/mmio_bridge_pkg.sv
// ---------------------------------------------------------------------------
// mmio_bridge_pkg
// Shared definitions for the CPU-to-MMIO bridge: FSM state type, default
// slot map (4 slots, 32-bit base/limit each, slot i at bits [32i+:32]),
// default timeout and the width of the timeout counter.
// ---------------------------------------------------------------------------
package mmio_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam int DEF_NSLOT   = 4;
    localparam int DEF_DW      = 32;
    localparam int DEF_TMO_CYC = 15;
    localparam int TMO_W       = 4;

    localparam logic [DEF_NSLOT*32-1:0] DEF_SLOT_BASE  =
        {32'h0000_7f20, 32'h0000_7f10, 32'h0000_7f00, 32'h0000_0000};
    localparam logic [DEF_NSLOT*32-1:0] DEF_SLOT_LIMIT =
        {32'h0000_7f23, 32'h0000_7f1b, 32'h0000_7f0b, 32'h0000_2fff};

endpackage

// File: rtl/mmio_bus_bridge_if.sv
// ---------------------------------------------------------------------------
// mmio_bus_bridge_if
// Bundles the CPU request/response port, the device-side bus and the fault
// log signals of the bridge.
//   modport slave  : the bridge's view (CPU requests in, device bus out)
//   modport master : the environment's view (CPU + peripherals)
// Parameters: NSLOT device slots, DW data width.
// ---------------------------------------------------------------------------
interface mmio_bus_bridge_if #(
    parameter int NSLOT = 4,
    parameter int DW    = 32
);
    // CPU side
    logic              cpu_req;
    logic [31:0]       cpu_addr;
    logic [3:0]        cpu_byteen;
    logic [DW-1:0]     cpu_wdata;
    logic [31:0]       cpu_pc;
    logic              cpu_ready;
    logic [DW-1:0]     cpu_rdata;
    logic              cpu_err;
    // Device side
    logic [NSLOT-1:0]  dev_sel;
    logic [31:0]       dev_addr;
    logic [DW-1:0]     dev_wdata;
    logic [3:0]        dev_byteen;
    logic              dev_we;
    logic [31:0]       dev_pc;
    logic [NSLOT*DW-1:0] dev_rdata;
    logic [NSLOT-1:0]  dev_ack;
    // Fault log
    logic              fault_valid;
    logic [31:0]       fault_addr;
    logic [31:0]       fault_pc;
    logic              fault_clr;

    modport slave (
        input  cpu_req, cpu_addr, cpu_byteen, cpu_wdata, cpu_pc,
        output cpu_ready, cpu_rdata, cpu_err,
        output dev_sel, dev_addr, dev_wdata, dev_byteen, dev_we, dev_pc,
        input  dev_rdata, dev_ack,
        output fault_valid, fault_addr, fault_pc,
        input  fault_clr
    );

    modport master (
        output cpu_req, cpu_addr, cpu_byteen, cpu_wdata, cpu_pc,
        input  cpu_ready, cpu_rdata, cpu_err,
        input  dev_sel, dev_addr, dev_wdata, dev_byteen, dev_we, dev_pc,
        output dev_rdata, dev_ack,
        input  fault_valid, fault_addr, fault_pc,
        output fault_clr
    );
endinterface

// File: rtl/mmio_addr_decoder.sv
// ---------------------------------------------------------------------------
// mmio_addr_decoder
// Combinational address decoder. Slot i hits when
// base_i <= addr <= limit_i; the lowest hitting slot wins on overlap.
// Ports:
//   i_addr  in  32     byte address
//   o_sel   out NSLOT  one-hot select (all zero on a miss)
//   o_hit   out 1      any slot hit
// ---------------------------------------------------------------------------
module mmio_addr_decoder #(
    parameter int                     NSLOT      = 4,
    parameter logic [NSLOT*32-1:0]    SLOT_BASE  = '0,
    parameter logic [NSLOT*32-1:0]    SLOT_LIMIT = '0
) (
    input  logic [31:0]      i_addr,
    output logic [NSLOT-1:0] o_sel,
    output logic             o_hit
);
    logic [NSLOT-1:0] w_hit;

    generate
        for (genvar gi = 0; gi < NSLOT; gi++) begin : g_slot
            assign w_hit[gi] = (i_addr >= SLOT_BASE[32*gi +: 32]) &&
                               (i_addr <= SLOT_LIMIT[32*gi +: 32]);
        end
    endgenerate

    // Keep only the lowest set bit of the hit vector.
    always_comb begin
        logic w_found;
        w_found = 1'b0;
        o_sel   = '0;
        for (int i = 0; i < NSLOT; i++) begin
            if (w_hit[i] && !w_found) begin
                o_sel[i] = 1'b1;
                w_found  = 1'b1;
            end
        end
    end

    assign o_hit = |w_hit;
endmodule

// File: rtl/mmio_bus_bridge.sv
// ---------------------------------------------------------------------------
// mmio_bus_bridge
// CPU-to-MMIO bridge between the M-stage memory port and NSLOT peripherals.
// A request is decoded against the slot map; on a hit the latched request is
// presented to the selected slot until it acks or the timeout expires, on a
// miss an error response is returned directly. The response is a one-cycle
// cpu_ready pulse carrying cpu_rdata / cpu_err.
// Ports:
//   clk    in  system clock, rising edge
//   reset  in  asynchronous, active-high
//   bus    mmio_bus_bridge_if.slave (CPU port, device bus, fault log)
// Optional feature: define BRIDGE_FAULT_LOG_EN to keep a sticky record of the
// first error response (address and PC); otherwise fault_* outputs are 0
// and fault_clr is ignored.
// ---------------------------------------------------------------------------
module mmio_bus_bridge
    import mmio_bridge_pkg::*;
#(
    parameter int                  NSLOT      = DEF_NSLOT,
    parameter int                  DW         = DEF_DW,
    parameter int                  TMO_CYC    = DEF_TMO_CYC,
    parameter logic [NSLOT*32-1:0] SLOT_BASE  = DEF_SLOT_BASE,
    parameter logic [NSLOT*32-1:0] SLOT_LIMIT = DEF_SLOT_LIMIT
) (
    input  logic               clk,
    input  logic               reset,
    mmio_bus_bridge_if.slave   bus
);
    // The counter starts at 0 in the first ACCESS cycle, so the cycle in
    // which it reads TMO_CYC-1 is the TMO_CYC-th ACCESS cycle without ack.
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);

    state_t              r_state, w_state_next;
    logic [NSLOT-1:0]    r_sel;
    logic [31:0]         r_addr, r_pc;
    logic [DW-1:0]       r_wdata, r_rdata;
    logic [3:0]          r_byteen;
    logic                r_err;
    logic [TMO_W-1:0]    r_tmo;

    logic [NSLOT-1:0]    w_dec_sel;
    logic                w_dec_hit;
    logic                w_ack;
    logic                w_tmo_hit;
    logic                w_in_access;
    logic                w_in_resp;
    logic [DW-1:0]       w_sel_rdata;

    mmio_addr_decoder #(
        .NSLOT      (NSLOT),
        .SLOT_BASE  (SLOT_BASE),
        .SLOT_LIMIT (SLOT_LIMIT)
    ) u_dec (
        .i_addr (bus.cpu_addr),
        .o_sel  (w_dec_sel),
        .o_hit  (w_dec_hit)
    );

    assign w_in_access = (r_state == ACCESS);
    assign w_in_resp   = (r_state == RESP);
    // Only the selected slot's ack counts; strays from other slots are masked.
    assign w_ack       = |(bus.dev_ack & r_sel);
    assign w_tmo_hit   = (r_tmo == TMO_LAST);

    always_comb begin
        w_sel_rdata = '0;
        for (int i = 0; i < NSLOT; i++) begin
            if (r_sel[i]) begin
                w_sel_rdata = w_sel_rdata | bus.dev_rdata[DW*i +: DW];
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE:    if (bus.cpu_req) w_state_next = w_dec_hit ? ACCESS : RESP;
            ACCESS:  if (w_ack || w_tmo_hit) w_state_next = RESP;
            RESP:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Request latches, response registers and timeout counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sel    <= '0;
            r_addr   <= '0;
            r_pc     <= '0;
            r_wdata  <= '0;
            r_byteen <= '0;
            r_rdata  <= '0;
            r_err    <= 1'b0;
            r_tmo    <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (bus.cpu_req) begin
                        r_addr   <= bus.cpu_addr;
                        r_pc     <= bus.cpu_pc;
                        r_wdata  <= bus.cpu_wdata;
                        r_byteen <= bus.cpu_byteen;
                        r_sel    <= w_dec_sel;
                        r_rdata  <= '0;
                        r_err    <= ~w_dec_hit;
                        r_tmo    <= '0;
                    end
                end
                ACCESS: begin
                    // Ack is tested first so it wins over a coincident timeout.
                    if (w_ack) begin
                        r_rdata <= (|r_byteen) ? '0 : w_sel_rdata;
                        r_err   <= 1'b0;
                    end else if (w_tmo_hit) begin
                        r_rdata <= '0;
                        r_err   <= 1'b1;
                    end else begin
                        r_tmo   <= r_tmo + 1'b1;
                    end
                end
                RESP: begin
                    r_sel <= '0;
                    r_tmo <= '0;
                end
                default: ;
            endcase
        end
    end

    // Device bus is only driven while a slot is being accessed.
    assign bus.dev_sel    = w_in_access ? r_sel    : '0;
    assign bus.dev_addr   = w_in_access ? r_addr   : '0;
    assign bus.dev_wdata  = w_in_access ? r_wdata  : '0;
    assign bus.dev_pc     = w_in_access ? r_pc     : '0;
    assign bus.dev_byteen = (|bus.dev_sel) ? r_byteen : 4'h0;
    assign bus.dev_we     = |bus.dev_byteen;

    assign bus.cpu_ready  = w_in_resp;
    assign bus.cpu_rdata  = w_in_resp ? r_rdata : '0;
    assign bus.cpu_err    = w_in_resp & r_err;

`ifdef BRIDGE_FAULT_LOG_EN
    logic        r_fault_valid;
    logic [31:0] r_fault_addr, r_fault_pc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fault_valid <= 1'b0;
            r_fault_addr  <= '0;
            r_fault_pc    <= '0;
        end else if (w_in_resp && r_err) begin
            // Set wins over a simultaneous clear; only the first fault is kept.
            r_fault_valid <= 1'b1;
            if (!r_fault_valid) begin
                r_fault_addr <= r_addr;
                r_fault_pc   <= r_pc;
            end
        end else if (bus.fault_clr) begin
            r_fault_valid <= 1'b0;
        end
    end

    assign bus.fault_valid = r_fault_valid;
    assign bus.fault_addr  = r_fault_addr;
    assign bus.fault_pc    = r_fault_pc;
`else
    logic w_unused_fault_clr;
    assign w_unused_fault_clr = bus.fault_clr;

    assign bus.fault_valid = 1'b0;
    assign bus.fault_addr  = '0;
    assign bus.fault_pc    = '0;
`endif

endmodule

// File: tb/tb_mmio_bus_bridge.sv
module tb_mmio_bus_bridge;
    localparam int TMO_CYC = 15;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mmio_bus_bridge_if #(.NSLOT(4), .DW(32)) bus();

    mmio_bus_bridge dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] ref_base  [4] = '{32'h0000_0000, 32'h0000_7f00, 32'h0000_7f10, 32'h0000_7f20};
    logic [31:0] ref_limit [4] = '{32'h0000_2fff, 32'h0000_7f0b, 32'h0000_7f1b, 32'h0000_7f23};
    logic [31:0] dev_data  [4];

    // Reference model: which slot an address maps to (-1 = unmapped).
    function automatic int ref_decode(input logic [31:0] addr);
        for (int i = 0; i < 4; i++)
            if (addr >= ref_base[i] && addr <= ref_limit[i]) return i;
        return -1;
    endfunction

    // Reference model: response expected for a request. ack_at is the
    // ACCESS cycle index (0-based) in which the device acks, -1 = never.
    // Latency counts rising edges from the request being presented in IDLE.
    function automatic void ref_expect(input logic [31:0] addr, input logic [3:0] be,
                                       input int ack_at, output int lat,
                                       output logic [31:0] rdata, output logic err,
                                       output logic [3:0] sel);
        int slot;
        slot = ref_decode(addr);
        sel  = (slot >= 0) ? 4'(1 << slot) : 4'b0;
        if (slot < 0) begin
            lat = 1; err = 1'b1; rdata = '0;
        end else if (ack_at >= 0 && ack_at < TMO_CYC) begin
            lat = 2 + ack_at; err = 1'b0; rdata = (be != 4'h0) ? 32'h0 : dev_data[slot];
        end else begin
            lat = TMO_CYC + 1; err = 1'b1; rdata = '0;
        end
    endfunction

    task automatic rand_devdata();
        for (int i = 0; i < 4; i++) dev_data[i] = $urandom;
    endtask

    // Drives one request and plays the addressed device. Ends right after
    // the edge on which cpu_ready is seen (DUT in RESP). When b2b is set the
    // request is presented during that RESP cycle of the previous one.
    task automatic run_txn(input string tag, input logic [31:0] addr, input logic [3:0] be,
                           input logic [31:0] wdata, input int ack_at, input bit stray,
                           input bit drop, input bit b2b,
                           output int lat, output logic [31:0] rdata, output logic err,
                           output bit sel_ok, output bit drv_ok, output bit sel_seen,
                           output bit sel_drop_ok, output bit pulse_ok, output logic [31:0] pc);
        int n, k, acc_edge, e_lat;
        logic [31:0] e_rd;
        logic e_err;
        logic [3:0] e_sel;
        bit got;
        ref_expect(addr, be, ack_at, e_lat, e_rd, e_err, e_sel);
        if (!b2b) begin
            @(posedge clk); #1;
        end
        for (int i = 0; i < 4; i++) bus.dev_rdata[32*i +: 32] = dev_data[i];
        pc = $urandom;
        bus.cpu_req = 1'b1; bus.cpu_addr = addr; bus.cpu_byteen = be;
        bus.cpu_wdata = wdata; bus.cpu_pc = pc; bus.dev_ack = '0;
        acc_edge = b2b ? 2 : 1;
        lat = -1; rdata = '0; err = 1'b0; sel_ok = 1; drv_ok = 1; sel_seen = 0;
        sel_drop_ok = 1; pulse_ok = 1; got = 0; n = 0;
        while (!got && n < 40) begin
            @(posedge clk); #1; n++;
            if (bus.dev_sel != 4'b0) sel_seen = 1;
            if (drop && n == acc_edge) bus.cpu_req = 1'b0;
            if (b2b && n == 1) begin
                if (bus.cpu_ready !== 1'b0) pulse_ok = 0;
            end else if (bus.cpu_ready === 1'b1) begin
                got = 1; lat = b2b ? n - 1 : n;
                rdata = bus.cpu_rdata; err = bus.cpu_err;
                if (bus.dev_sel !== 4'b0) sel_drop_ok = 0;
            end else begin
                k = n - acc_edge;
                if (k >= 0) begin
                    if (bus.dev_sel !== e_sel) sel_ok = 0;
                    if (bus.dev_addr !== addr || bus.dev_wdata !== wdata || bus.dev_pc !== pc ||
                        bus.dev_byteen !== be || bus.dev_we !== (be != 4'h0)) drv_ok = 0;
                    bus.dev_ack = ((k == ack_at) ? e_sel : 4'b0) |
                                  (stray ? (4'($urandom) & ~e_sel) : 4'b0);
                end
            end
        end
        bus.cpu_req = 1'b0; bus.dev_ack = '0;
        $display("txn %s addr=%h be=%h lat=%0d rdata=%h err=%b", tag, addr, be, lat, rdata, err);
    endtask

    task automatic test_reset();
        bus.cpu_req = 0; bus.cpu_addr = 0; bus.cpu_byteen = 0; bus.cpu_wdata = 0;
        bus.cpu_pc = 0; bus.dev_rdata = '0; bus.dev_ack = 0; bus.fault_clr = 0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.cpu_ready !== 1'b0 || bus.cpu_err !== 1'b0 || bus.cpu_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_cpu: ready=%b err=%b rdata=%h required 0/0/0", bus.cpu_ready, bus.cpu_err, bus.cpu_rdata);
        end
        checks++;
        if (bus.dev_sel !== 4'h0 || bus.dev_we !== 1'b0 || bus.dev_byteen !== 4'h0 || bus.dev_addr !== 32'h0) begin
            errors++;
            $display("FAIL reset_dev: sel=%b we=%b be=%h addr=%h required all 0", bus.dev_sel, bus.dev_we, bus.dev_byteen, bus.dev_addr);
        end
        checks++;
        if (bus.fault_valid !== 1'b0 || bus.fault_addr !== 32'h0 || bus.fault_pc !== 32'h0) begin
            errors++;
            $display("FAIL reset_fault: valid=%b addr=%h pc=%h required 0", bus.fault_valid, bus.fault_addr, bus.fault_pc);
        end
        @(negedge clk) reset = 1'b0;
    endtask

    task automatic test_read();
        int lat; logic [31:0] rd, pc; logic err; bit s_ok, d_ok, s_seen, s_drop, p_ok;
        rand_devdata();
        dev_data[0] = 32'hDEAD_BEEF;
        run_txn("read", 32'h0000_1000, 4'h0, 32'h0, 0, 0, 0, 0, lat, rd, err, s_ok, d_ok, s_seen, s_drop, p_ok, pc);
        checks++;
        if (lat !== 2) begin errors++; $display("FAIL read_latency: got %0d required 2", lat); end
        checks++;
        if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL read_data: got %h required deadbeef", rd); end
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL read_err: got %b required 0", err); end
        checks++;
        if (!s_ok || !s_drop) begin errors++; $display("FAIL read_sel: sel_ok=%0d drop_ok=%0d required 1/1", s_ok, s_drop); end
    endtask

    task automatic test_write();
        int lat; logic [31:0] rd, pc, wd; logic err; bit s_ok, d_ok, s_seen, s_drop, p_ok;
        rand_devdata();
        wd = $urandom;
        run_txn("write", 32'h0000_7f04, 4'hF, wd, 1, 0, 0, 0, lat, rd, err, s_ok, d_ok, s_seen, s_drop, p_ok, pc);
        checks++;
        if (!s_ok) begin errors++; $display("FAIL write_sel: dev_sel differed from required 0010"); end
        checks++;
        if (!d_ok) begin errors++; $display("FAIL write_drive: dev_addr/wdata/pc/byteen/we differed from request"); end
        checks++;
        if (lat !== 3 || err !== 1'b0 || rd !== 32'h0) begin
            errors++; $display("FAIL write_resp: lat=%0d err=%b rdata=%h required 3/0/0", lat, err, rd);
        end
    endtask

    task automatic test_unmapped();
        int lat; logic [31:0] rd, pc; logic err; bit s_ok, d_ok, s_seen, s_drop, p_ok;
        rand_devdata();
        run_txn("unmapped", 32'h0000_5000, 4'h3, 32'h1234_5678, 0, 0, 0, 0, lat, rd, err, s_ok, d_ok, s_seen, s_drop, p_ok, pc);
        checks++;
        if (lat !== 1 || err !== 1'b1 || rd !== 32'h0) begin
            errors++; $display("FAIL unmapped_resp: lat=%0d err=%b rdata=%h required 1/1/0", lat, err, rd);
        end
        checks++;
        if (s_seen) begin errors++; $display("FAIL unmapped_sel: dev_sel became nonzero, required never"); end
    endtask

    task automatic test_timeout();
        int lat; logic [31:0] rd, pc; logic err; bit s_ok, d_ok, s_seen, s_drop, p_ok;
        // Clear any fault logged by earlier errors so this one is the first.
        @(negedge clk) bus.fault_clr = 1'b1;
        @(negedge clk) bus.fault_clr = 1'b0;
        rand_devdata();
        run_txn("timeout", 32'h0000_7f10, 4'h0, 32'h0, -1, 0, 0, 0, lat, rd, err, s_ok, d_ok, s_seen, s_drop, p_ok, pc);
        checks++;
        if (lat !== TMO_CYC + 1 || err !== 1'b1 || rd !== 32'h0) begin
            errors++; $display("FAIL timeout_resp: lat=%0d err=%b rdata=%h required %0d/1/0", lat, err, rd, TMO_CYC + 1);
        end
        checks++;
        if (!s_ok || !s_drop) begin errors++; $display("FAIL timeout_sel: sel_ok=%0d drop_ok=%0d required 1/1", s_ok, s_drop); end
        @(posedge clk); #1;
        checks++;
`ifdef BRIDGE_FAULT_LOG_EN
        if (bus.fault_valid !== 1'b1 || bus.fault_addr !== 32'h0000_7f10 || bus.fault_pc !== pc) begin
            errors++; $display("FAIL fault_log: valid=%b addr=%h pc=%h required 1/00007f10/%h", bus.fault_valid, bus.fault_addr, bus.fault_pc, pc);
        end
`else
        if (bus.fault_valid !== 1'b0 || bus.fault_addr !== 32'h0 || bus.fault_pc !== 32'h0) begin
            errors++; $display("FAIL fault_tied: valid=%b addr=%h pc=%h required 0", bus.fault_valid, bus.fault_addr, bus.fault_pc);
        end
`endif
    endtask

    task automatic test_ack_at_timeout();
        int lat; logic [31:0] rd, pc; logic err; bit s_ok, d_ok, s_seen, s_drop, p_ok;
        rand_devdata();
        run_txn("ack_tmo", 32'h0000_7f21, 4'h0, 32'h0, TMO_CYC - 1, 0, 0, 0, lat, rd, err, s_ok, d_ok, s_seen, s_drop, p_ok, pc);
        checks++;
        if (lat !== TMO_CYC + 1 || err !== 1'b0 || rd !== dev_data[3]) begin
            errors++; $display("FAIL ack_timeout: lat=%0d err=%b rdata=%h required %0d/0/%h", lat, err, rd, TMO_CYC + 1, dev_data[3]);
        end
    endtask

    task automatic test_stray_ack();
        int lat; logic [31:0] rd, pc; logic err; bit s_ok, d_ok, s_seen, s_drop, p_ok;
        rand_devdata();
        run_txn("stray", 32'h0000_0200, 4'h0, 32'h0, 3, 1, 0, 0, lat, rd, err, s_ok, d_ok, s_seen, s_drop, p_ok, pc);
        checks++;
        if (lat !== 5 || err !== 1'b0 || rd !== dev_data[0]) begin
            errors++; $display("FAIL stray_ack: lat=%0d err=%b rdata=%h required 5/0/%h", lat, err, rd, dev_data[0]);
        end
    endtask

    task automatic test_drop_req();
        int lat; logic [31:0] rd, pc; logic err; bit s_ok, d_ok, s_seen, s_drop, p_ok;
        rand_devdata();
        run_txn("drop", 32'h0000_7f1b, 4'h0, 32'h0, 2, 0, 1, 0, lat, rd, err, s_ok, d_ok, s_seen, s_drop, p_ok, pc);
        checks++;
        if (lat !== 4 || err !== 1'b0 || rd !== dev_data[2]) begin
            errors++; $display("FAIL drop_req: lat=%0d err=%b rdata=%h required 4/0/%h", lat, err, rd, dev_data[2]);
        end
    endtask

    task automatic test_back_to_back();
        int lat; logic [31:0] rd, pc; logic err; bit s_ok, d_ok, s_seen, s_drop, p_ok;
        rand_devdata();
        run_txn("b2b_a", 32'h0000_7f00, 4'h0, 32'h0, 0, 0, 0, 0, lat, rd, err, s_ok, d_ok, s_seen, s_drop, p_ok, pc);
        run_txn("b2b_b", 32'h0000_2fff, 4'h0, 32'h0, 1, 0, 0, 1, lat, rd, err, s_ok, d_ok, s_seen, s_drop, p_ok, pc);
        checks++;
        if (!p_ok) begin errors++; $display("FAIL b2b_pulse: cpu_ready high two cycles, required one"); end
        checks++;
        if (lat !== 3 || err !== 1'b0 || rd !== dev_data[0]) begin
            errors++; $display("FAIL b2b_resp: lat=%0d err=%b rdata=%h required 3/0/%h", lat, err, rd, dev_data[0]);
        end
    endtask

    task automatic test_reset_mid();
        int lat; logic [31:0] rd, pc; logic err; bit s_ok, d_ok, s_seen, s_drop, p_ok;
        @(posedge clk); #1;
        bus.cpu_req = 1'b1; bus.cpu_addr = 32'h0000_7f22; bus.cpu_byteen = 4'h0; bus.dev_ack = '0;
        repeat (3) begin @(posedge clk); #1; end
        checks++;
        if (bus.dev_sel !== 4'b1000) begin errors++; $display("FAIL rstmid_presel: dev_sel=%b required 1000", bus.dev_sel); end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (bus.dev_sel !== 4'b0 || bus.cpu_ready !== 1'b0) begin
            errors++; $display("FAIL rstmid_async: dev_sel=%b ready=%b required 0000/0", bus.dev_sel, bus.cpu_ready);
        end
        bus.cpu_req = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (bus.cpu_ready !== 1'b0) begin errors++; $display("FAIL rstmid_noready: ready=%b required 0", bus.cpu_ready); end
        @(negedge clk) reset = 1'b0;
        rand_devdata();
        run_txn("after_rst", 32'h0000_7f23, 4'h0, 32'h0, 0, 0, 0, 0, lat, rd, err, s_ok, d_ok, s_seen, s_drop, p_ok, pc);
        checks++;
        if (lat !== 2 || err !== 1'b0 || rd !== dev_data[3]) begin
            errors++; $display("FAIL rstmid_next: lat=%0d err=%b rdata=%h required 2/0/%h", lat, err, rd, dev_data[3]);
        end
    endtask

    task automatic test_random();
        int lat, e_lat, slot, ack_at; logic [31:0] rd, pc, e_rd, addr, wd; logic err, e_err;
        logic [3:0] e_sel, be; bit s_ok, d_ok, s_seen, s_drop, p_ok, b2b, stray;
        b2b = 0;
        for (int t = 0; t < 40; t++) begin
            rand_devdata();
            slot = $urandom_range(0, 3);
            case ($urandom_range(0, 5))
                0: addr = ref_base[slot] + $urandom_range(0, ref_limit[slot] - ref_base[slot]);
                1: addr = ref_base[slot];
                2: addr = ref_limit[slot];
                3: addr = ref_limit[slot] + 1;
                4: addr = ref_base[slot] - 1;
                default: addr = $urandom;
            endcase
            be     = $urandom_range(0, 1) ? 4'($urandom) : 4'h0;
            wd     = $urandom;
            ack_at = ($urandom_range(0, 7) == 0) ? -1 : $urandom_range(0, 6);
            stray  = $urandom_range(0, 1);
            ref_expect(addr, be, ack_at, e_lat, e_rd, e_err, e_sel);
            run_txn("random", addr, be, wd, ack_at, stray, 0, b2b, lat, rd, err, s_ok, d_ok, s_seen, s_drop, p_ok, pc);
            checks++;
            if (lat !== e_lat || err !== e_err || rd !== e_rd) begin
                errors++; $display("FAIL random_resp[%0d]: addr=%h lat=%0d err=%b rdata=%h required %0d/%b/%h", t, addr, lat, err, rd, e_lat, e_err, e_rd);
            end
            checks++;
            if (!s_ok || !d_ok || !s_drop || !p_ok || (e_sel == 4'b0 && s_seen)) begin
                errors++; $display("FAIL random_bus[%0d]: addr=%h sel_ok=%0d drv_ok=%0d drop_ok=%0d pulse_ok=%0d seen=%0d required sel %b", t, addr, s_ok, d_ok, s_drop, p_ok, s_seen, e_sel);
            end
            b2b = $urandom_range(0, 1);
        end
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_unmapped();
        test_timeout();
        test_ack_at_timeout();
        test_stray_ack();
        test_drop_req();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
